// File: rtl/bridge_controller_if.sv
// Signal bundle between the drawbridge sequencer and its environment.
// The master modport is the controller; the slave modport is the plant/sensor side.
interface bridge_controller_if;
    logic BoatReq;
    logic ExistCar;
    logic BridgeUp;
    logic BridgeDown;
    logic CarGreen;
    logic CarYellow;
    logic CarRed;
    logic BoatGreen;
    logic MotorUp;
    logic MotorDown;
    logic Fault;

    modport master (
        input  BoatReq, ExistCar, BridgeUp, BridgeDown,
        output CarGreen, CarYellow, CarRed, BoatGreen, MotorUp, MotorDown, Fault
    );

    modport slave (
        output BoatReq, ExistCar, BridgeUp, BridgeDown,
        input  CarGreen, CarYellow, CarRed, BoatGreen, MotorUp, MotorDown, Fault
    );
endinterface

// File: rtl/bridge_controller.sv
// Drawbridge sequencing FSM (Moore): road light, boat signal and lift motor.
// Optional motion watchdog enabled by defining BRIDGE_WATCHDOG_EN.
module bridge_controller #(
    parameter int YELLOW_CYCLES   = 4,
    parameter int BOAT_MIN_CYCLES = 8,
    parameter int MOTION_TIMEOUT  = 32,
    parameter int CNT_W           = 8
) (
    input logic              Clk,
    input logic              Reset,
    bridge_controller_if.master bus
);

    typedef enum logic [2:0] {
        OPEN       = 3'd0,
        CLEAR      = 3'd1,
        WAIT_EMPTY = 3'd2,
        RAISE      = 3'd3,
        BOAT       = 3'd4,
        LOWER      = 3'd5,
        FAULT      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] yellowLast = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] boatLast   = CNT_W'(BOAT_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] motionLast = CNT_W'(MOTION_TIMEOUT - 1);
`ifdef BRIDGE_WATCHDOG_EN
    localparam bit watchdogEn = 1'b1;
`else
    localparam bit watchdogEn = 1'b0;
`endif

    // Output vector order: {CarGreen, CarYellow, CarRed, BoatGreen, MotorUp, MotorDown, Fault}
    function automatic logic [6:0] decodeOutputs(input state_t s);
        logic [6:0] o;
        case (s)
            OPEN:       o = 7'b100_0000;
            CLEAR:      o = 7'b010_0000;
            WAIT_EMPTY: o = 7'b001_0000;
            RAISE:      o = 7'b001_0100;
            BOAT:       o = 7'b001_1000;
            LOWER:      o = 7'b001_0010;
            FAULT:      o = 7'b001_0001;
            default:    o = 7'b001_0001;
        endcase
        return o;
    endfunction

    state_t           stateR;
    state_t           nextStateS;
    logic [CNT_W-1:0] timerR;
    logic [6:0]       outR;
    logic             motionExpiredS;
    logic             bothLimitsS;

    assign motionExpiredS = watchdogEn && (timerR == motionLast);
    assign bothLimitsS    = bus.BridgeUp && bus.BridgeDown;

    // Next-state selection; contradictory limit switches override every state.
    always_comb begin
        nextStateS = stateR;
        if (bothLimitsS) begin
            nextStateS = FAULT;
        end else begin
            case (stateR)
                OPEN: begin
                    if (bus.BoatReq) nextStateS = CLEAR;
                    else             nextStateS = OPEN;
                end
                CLEAR: begin
                    if (timerR == yellowLast) nextStateS = WAIT_EMPTY;
                    else                      nextStateS = CLEAR;
                end
                WAIT_EMPTY: begin
                    if (!bus.BoatReq)       nextStateS = OPEN;
                    else if (!bus.ExistCar) nextStateS = RAISE;
                    else                    nextStateS = WAIT_EMPTY;
                end
                RAISE: begin
                    if (bus.BridgeUp)       nextStateS = BOAT;
                    else if (motionExpiredS) nextStateS = FAULT;
                    else                    nextStateS = RAISE;
                end
                BOAT: begin
                    if ((timerR >= boatLast) && !bus.BoatReq) nextStateS = LOWER;
                    else                                      nextStateS = BOAT;
                end
                LOWER: begin
                    if (bus.BridgeDown)      nextStateS = OPEN;
                    else if (motionExpiredS) nextStateS = FAULT;
                    else                     nextStateS = LOWER;
                end
                FAULT:   nextStateS = FAULT;
                default: nextStateS = FAULT;
            endcase
        end
    end

    // State, phase timer and registered output decode; reset lands in LOWER so the deck comes down.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateR <= LOWER;
            timerR <= {CNT_W{1'b0}};
            outR   <= 7'b001_0010;
        end else begin
            stateR <= nextStateS;
            outR   <= decodeOutputs(nextStateS);
            if (nextStateS != stateR) begin
                timerR <= {CNT_W{1'b0}};
            end else if (timerR != {CNT_W{1'b1}}) begin
                timerR <= timerR + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                timerR <= timerR;
            end
        end
    end

    assign bus.CarGreen  = outR[6];
    assign bus.CarYellow = outR[5];
    assign bus.CarRed    = outR[4];
    assign bus.BoatGreen = outR[3];
    assign bus.MotorUp   = outR[2];
    assign bus.MotorDown = outR[1];
    assign bus.Fault     = outR[0];

endmodule

// File: tb/tb_bridge_controller.sv
// Self-checking bench for bridge_controller: directed test-plan steps plus
// randomized traffic, compared every cycle against a phase-level reference model.
module tb_bridge_controller;

    localparam int YC = 4;
    localparam int BMC = 8;
    localparam int MT = 32;
    localparam int CW = 8;
`ifdef BRIDGE_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    bridge_controller_if bus ();

    bridge_controller #(
        .YELLOW_CYCLES(YC), .BOAT_MIN_CYCLES(BMC), .MOTION_TIMEOUT(MT), .CNT_W(CW)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus.master)
    );

    always #5 Clk = ~Clk;

    typedef enum int {M_OPEN, M_CLEAR, M_WAIT, M_RAISE, M_BOAT, M_LOWER, M_FAULT} phase_t;

    phase_t phase;
    int yellowLeft;
    int greenAge;
    int motionAge;
    int vectors = 0;
    int miscompares = 0;
    int faultDwell;

    // {CarGreen, CarYellow, CarRed, BoatGreen, MotorUp, MotorDown, Fault}
    function automatic logic [6:0] expectOut(input phase_t p);
        case (p)
            M_OPEN:  return 7'b100_0000;
            M_CLEAR: return 7'b010_0000;
            M_WAIT:  return 7'b001_0000;
            M_RAISE: return 7'b001_0100;
            M_BOAT:  return 7'b001_1000;
            M_LOWER: return 7'b001_0010;
            default: return 7'b001_0001;
        endcase
    endfunction

    task automatic check(input string tag);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {bus.CarGreen, bus.CarYellow, bus.CarRed, bus.BoatGreen,
               bus.MotorUp, bus.MotorDown, bus.Fault};
        exp = expectOut(phase);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic b, input logic c, input logic u, input logic d);
        bus.BoatReq    = b;
        bus.ExistCar   = c;
        bus.BridgeUp   = u;
        bus.BridgeDown = d;
    endtask

    task automatic modelStep(input logic b, input logic c, input logic u, input logic d);
        if (u && d) begin
            phase = M_FAULT;
        end else begin
            case (phase)
                M_OPEN: if (b) begin phase = M_CLEAR; yellowLeft = YC; end
                M_CLEAR: begin
                    yellowLeft--;
                    if (yellowLeft == 0) phase = M_WAIT;
                end
                M_WAIT: begin
                    if (!b) phase = M_OPEN;
                    else if (!c) begin phase = M_RAISE; motionAge = 0; end
                end
                M_RAISE: begin
                    if (u) begin phase = M_BOAT; greenAge = 1; end
                    else begin
                        motionAge++;
                        if (WD && motionAge >= MT) phase = M_FAULT;
                    end
                end
                M_BOAT: begin
                    if (greenAge >= BMC && !b) begin phase = M_LOWER; motionAge = 0; end
                    else greenAge++;
                end
                M_LOWER: begin
                    if (d) phase = M_OPEN;
                    else begin
                        motionAge++;
                        if (WD && motionAge >= MT) phase = M_FAULT;
                    end
                end
                default: phase = M_FAULT;
            endcase
        end
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        modelStep(bus.BoatReq, bus.ExistCar, bus.BridgeUp, bus.BridgeDown);
        @(negedge Clk);
        check(tag);
    endtask

    // Asynchronous reset pulse taken between edges; releases with the deck reported down.
    task automatic pulseReset(input string tag);
        Reset = 1'b0;
        phase = M_LOWER;
        motionAge = 0;
        #1;
        check(tag);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        Reset = 1'b1;
        tick("reset_exit_open");
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        phase = M_LOWER;
        yellowLeft = 0; greenAge = 0; motionAge = 0;
        #1 Reset = 1'b0;
        #1 check("reset_values");
        @(negedge Clk);
        Reset = 1'b1;
        tick("first_edge_open");
        tick("open_idle");

        // Full cycle with an empty deck
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) tick("yellow");
        tick("wait_empty_red");
        tick("raise");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick("raise_travel");
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick("boat_green_1");
        tick("boat_green_2");
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) tick("boat_min_hold");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick("lower_travel");
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick("lowered_open");

        // Car on deck through CLEAR blocks the raise
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) tick("wait_car_on_deck");
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick("deck_empty_raise");
        tick("raise_after_empty");

        // Reset during RAISE drops MotorUp asynchronously
        @(negedge Clk);
        pulseReset("reset_mid_raise");

        // Boat withdraws while waiting for the deck
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (7) tick("wait_then_withdraw");
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick("withdraw_open");
        repeat (3) tick("withdraw_no_motor");

        // Both limits during BOAT -> sticky fault
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) tick("to_raise");
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick("to_boat");
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        tick("both_limits_fault");
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) tick("fault_sticky");
        @(negedge Clk);
        pulseReset("reset_from_fault");

        // Stalled raise: watchdog build faults after 32 MotorUp cycles, otherwise holds
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) tick("to_raise_stall");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (100) tick("raise_stalled");
        @(negedge Clk);
        pulseReset("reset_after_stall");

        // Randomized traffic
        faultDwell = 0;
        for (int i = 0; i < 1500; i++) begin
            logic b, c, u, d;
            b = bus.BoatReq;
            if ($urandom_range(7) == 0) b = ~b;
            c = ($urandom_range(2) == 0);
            u = ($urandom_range(5) == 0);
            d = ($urandom_range(5) == 0);
            if (u && d && ($urandom_range(40) != 0)) d = 1'b0;
            drive(b, c, u, d);
            tick("random");
            if (phase == M_FAULT) faultDwell++;
            else faultDwell = 0;
            if (faultDwell > 3) begin
                pulseReset("random_reset");
                faultDwell = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
